stereo_capture_buffer: RTL

Producer-side frame store for the disparity engine. It captures one left and one right greyscale frame from two byte-wide camera pixel streams into internal arrays and asserts `buffer_ready` when both frames are complete. It then serves pixels to the disparity engine's READ pass by combinational lookup on `buffer_href`/`buffer_vref`/`image_sel`. It is the writer end of the engine's `image_data`/`buffer_ready` read interface.

---
 rtl/stereo_capture_buffer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/stereo_capture_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stereo_capture_buffer                                        |
// | Description : Captures one left and one right greyscale frame from two     |
// |               byte-wide pixel streams and serves them by combinational     |
// |               lookup. Optional macro TEST_PATTERN_EN adds test_mode.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module stereo_capture_buffer #(
  parameter int IMG_W    = 20,
  parameter int IMG_H    = 7,
  parameter int TP_SHIFT = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       left_valid,
  input  logic       left_sof,
  input  logic [7:0] left_data,
  input  logic       right_valid,
  input  logic       right_sof,
  input  logic [7:0] right_data,
  input  logic [9:0] buffer_href,
  input  logic [9:0] buffer_vref,
  input  logic       image_sel,
`ifdef TEST_PATTERN_EN
  input  logic       test_mode,
`endif
  output logic [7:0] image_data,
  output logic       buffer_ready,
  output logic       busy,
  output logic       resync_err,
  output logic [7:0] frame_count
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_SOF = 2'd1;
  localparam logic [1:0] ST_CAPTURE  = 2'd2;
  localparam logic [1:0] ST_READY    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        resync_err_q, resync_err_d;
  logic [7:0]  frame_count_q, frame_count_d;
  logic        capturing;
  logic        addr_ok;
  logic        tp_mode;
  logic [1:0]  side_wr;
  logic [1:0]  side_done;
  logic [1:0]  side_resync;
  logic [15:0] side_rd;

`ifdef TEST_PATTERN_EN
  assign tp_mode = test_mode;
`else
  assign tp_mode = 1'b0;
`endif

  assign capturing = (state_q == ST_WAIT_SOF) || (state_q == ST_CAPTURE);
  assign addr_ok   = (buffer_href < 10'(IMG_W)) && (buffer_vref < 10'(IMG_H));

  // Index 0 is the left camera, index 1 the right camera.
  for (genvar s = 0; s < 2; s++) begin : g_side
    localparam int SHIFT = (s == 1) ? TP_SHIFT : 0;

    logic          valid;
    logic          sof;
    logic [7:0]    data;
    logic [CW-1:0] col_q, col_d, wr_col;
    logic [RW-1:0] row_q, row_d, wr_row;
    logic          started_q, started_d;
    logic          done_q, done_d;
    logic          wr_en;
    logic          resync;
    logic [7:0]    pattern;
    logic [7:0]    wdata;
    logic [7:0]    mem [0:IMG_W-1][0:IMG_H-1];

    assign valid = (s == 0) ? left_valid : right_valid;
    assign sof   = (s == 0) ? left_sof   : right_sof;
    assign data  = (s == 0) ? left_data  : right_data;

    assign pattern = 8'((4 * (int'(wr_col) + SHIFT)) + int'(wr_row));
    assign wdata   = tp_mode ? pattern : data;

    // An SOF beat always lands at (0,0); on a started side it is a resync.
    always_comb begin
      col_d     = col_q;
      row_d     = row_q;
      started_d = started_q;
      done_d    = done_q;
      wr_en     = 1'b0;
      resync    = 1'b0;
      wr_col    = col_q;
      wr_row    = row_q;
      if (start) begin
        col_d     = '0;
        row_d     = '0;
        started_d = 1'b0;
        done_d    = 1'b0;
      end else if (capturing && valid && !done_q && (sof || started_q)) begin
        wr_en     = 1'b1;
        started_d = 1'b1;
        if (sof) begin
          wr_col = '0;
          wr_row = '0;
          resync = started_q;
        end
        if (wr_col == LAST_COL) begin
          col_d = '0;
          if (wr_row == LAST_ROW) begin
            done_d = 1'b1;
          end else begin
            row_d = wr_row + 1'b1;
          end
        end else begin
          col_d = wr_col + 1'b1;
          row_d = wr_row;
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        col_q     <= '0;
        row_q     <= '0;
        started_q <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        col_q     <= col_d;
        row_q     <= row_d;
        started_q <= started_d;
        done_q    <= done_d;
      end
    end

    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[wr_col][wr_row] <= wdata;
      end
    end

    // Out-of-range addresses are masked to zero at the output mux.
    assign side_rd[8*s +: 8] = mem[buffer_href[CW-1:0]][buffer_vref[RW-1:0]];
    assign side_wr[s]        = wr_en;
    assign side_done[s]      = done_q;
    assign side_resync[s]    = resync;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_WAIT_SOF;
    end else begin
      case (state_q)
        ST_WAIT_SOF: if (|side_wr) state_d = ST_CAPTURE;
        ST_CAPTURE:  if (&side_done) state_d = ST_READY;
        default:     state_d = state_q;
      endcase
    end
  end

  always_comb begin
    resync_err_d  = resync_err_q | (|side_resync);
    frame_count_d = frame_count_q;
    if ((state_d == ST_READY) && (state_q != ST_READY)) begin
      frame_count_d = frame_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      resync_err_q  <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      resync_err_q  <= resync_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign image_data   = addr_ok ? (image_sel ? side_rd[15:8] : side_rd[7:0]) : 8'h00;
  assign buffer_ready = (state_q == ST_READY);
  assign busy         = capturing;
  assign resync_err   = resync_err_q;
  assign frame_count  = frame_count_q;

endmodule
`default_nettype wire
